// File: rtl/iir_stim_if.sv
// iir_stim_if: dv/d sample stream from iir_stim_gen to iir_filter.
// ready_in exists only when IIR_STIM_BACKPRESSURE_EN is defined.
interface iir_stim_if #(
  parameter int Ndint = 3,
  parameter int Ndfrac = 22
);
  logic dv_out;
  logic signed [Ndint-1:-Ndfrac] d_out;
`ifdef IIR_STIM_BACKPRESSURE_EN
  logic ready_in;
  modport master (output dv_out, output d_out, input ready_in);
  modport slave (input dv_out, input d_out, output ready_in);
`else
  modport master (output dv_out, output d_out);
  modport slave (input dv_out, input d_out);
`endif
endinterface

// File: rtl/iir_stim_gen.sv
// iir_stim_gen: impulse/step/square/noise sample source for iir_filter.
// Define IIR_STIM_BACKPRESSURE_EN to stall samples on smp.ready_in.
module iir_stim_gen #(
  parameter int Ndint = 3,
  parameter int Ndfrac = 22,
  parameter int SQ_LOG2 = 4,
  parameter int NOISE_SHR = 2,
  parameter logic [31:0] LFSR_SEED = 32'hACE1_2468
) (
  input  logic clk,
  input  logic resetn,
  input  logic start,
  input  logic stop,
  input  logic [1:0] mode,
  input  logic [15:0] rate_div,
  input  logic [15:0] length,
  input  logic signed [Ndint-1:-Ndfrac] amplitude,
  output logic busy,
  output logic done,
  iir_stim_if.master smp
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef enum logic [1:0] {M_IMP, M_STEP, M_SQ, M_NOISE} mode_t;

  localparam int W = Ndint + Ndfrac;
  localparam logic [31:0] TAPS = 32'h8020_0003;
  localparam logic [W-1:0] NEG_MAX = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] POS_MAX = {1'b0, {(W-1){1'b1}}};

  state_t state, state_nx;
  mode_t mode_q;
  logic [15:0] rate_q, len_q, n, rc;
  logic signed [W-1:0] amp_q, neg_a, noise, sample, d_q;
  logic [31:0] lfsr;
  logic first, go, dv, ready, fire, last;

`ifdef IIR_STIM_BACKPRESSURE_EN
  assign ready = smp.ready_in;
`else
  assign ready = 1'b1;
`endif

  assign go = state == IDLE && start && !stop;
  assign dv = state == RUN && rc == '0 && !stop;
  assign fire = dv && ready;
  assign last = len_q != '0 && n == len_q - 16'd1;
  assign busy = state == RUN;
  assign done = state == DONE;

  assign smp.dv_out = dv;
  assign smp.d_out = dv ? sample : d_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (go) state_nx = RUN;
      RUN: if (stop || (fire && last)) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // -A saturates so the most negative amplitude maps to +max
  always_comb begin
    neg_a = (amp_q == NEG_MAX) ? POS_MAX : -amp_q;
    noise = $signed(lfsr[31:32-W]) >>> NOISE_SHR;
    sample = '0;
    unique case (1'b1)
      mode_q == M_IMP: sample = first ? amp_q : '0;
      mode_q == M_STEP: sample = amp_q;
      mode_q == M_SQ: sample = n[SQ_LOG2] ? neg_a : amp_q;
      mode_q == M_NOISE: sample = noise;
      default: sample = '0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mode_q <= M_IMP;
      rate_q <= '0;
      len_q <= '0;
      amp_q <= '0;
      n <= '0;
      rc <= '0;
      lfsr <= LFSR_SEED;
      first <= 1'b0;
      d_q <= '0;
    end else if (go) begin
      mode_q <= mode_t'(mode);
      rate_q <= rate_div;
      len_q <= length;
      amp_q <= amplitude;
      n <= '0;
      rc <= '0;
      lfsr <= LFSR_SEED;
      first <= 1'b1;
      d_q <= '0;
    end else if (state == RUN) begin
      // a pending, unaccepted sample freezes the period counter
      if (!(dv && !ready))
        rc <= (rc == rate_q) ? '0 : rc + 16'd1;
      if (fire) begin
        n <= n + 16'd1;
        first <= 1'b0;
        d_q <= sample;
        lfsr <= {1'b0, lfsr[31:1]} ^ (lfsr[0] ? TAPS : '0);
      end
    end
  end

endmodule

// File: tb/tb_iir_stim_gen.sv
// tb_iir_stim_gen: directed vector table plus hand sequences.
// Covers reset, latching, stop, reset mid-run and optional backpressure.
module tb_iir_stim_gen;

  localparam logic [31:0] SEED = 32'hACE1_2468;
  localparam logic [31:0] TAPS = 32'h8020_0003;

  logic clk = 1'b0;
  logic resetn, start, stop;
  logic [1:0] mode;
  logic [15:0] rate_div, length;
  logic signed [2:-22] amplitude;
  logic busy, done;
  logic dv;
  logic [24:0] d;

  int total = 0;
  int bad = 0;

  iir_stim_if #(.Ndint(3), .Ndfrac(22)) sif ();

  iir_stim_gen dut (
    .clk(clk),
    .resetn(resetn),
    .start(start),
    .stop(stop),
    .mode(mode),
    .rate_div(rate_div),
    .length(length),
    .amplitude(amplitude),
    .busy(busy),
    .done(done),
    .smp(sif)
  );

  assign dv = sif.dv_out;
  assign d = sif.d_out;

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] md;
    logic [15:0] rate;
    logic [15:0] len;
    logic [24:0] amp;
    int stop_at;
    int exp_n;
    logic [24:0] exp_d0;
    int exp_done;
  } vec_t;

  vec_t tbl[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  function automatic logic [31:0] adv(input logic [31:0] lf);
    return {1'b0, lf[31:1]} ^ (lf[0] ? TAPS : 32'h0);
  endfunction

  function automatic logic [24:0] model(input logic [1:0] m,
      input logic [24:0] a, input int k, input logic [31:0] lf);
    logic [24:0] na;
    logic signed [24:0] t;
    na = (a == 25'h1000000) ? 25'h0FFFFFF : (~a + 25'd1);
    t = lf[31:7];
    case (m)
      2'd0: return (k == 0) ? a : 25'd0;
      2'd1: return a;
      2'd2: return k[4] ? na : a;
      default: return 25'(t >>> 2);
    endcase
  endfunction

  task automatic run(input int idx, input vec_t v);
    int cyc, cnt, done_cyc, herr, berr, terr;
    logic [31:0] lf;
    logic [24:0] last_d;
    mode = v.md;
    rate_div = v.rate;
    length = v.len;
    amplitude = v.amp;
    start = 1'b1;
    tick();
    start = 1'b0;
    cyc = 1; cnt = 0; done_cyc = -1;
    herr = 0; berr = 0; terr = 0;
    lf = SEED; last_d = '0;
    while (cyc < 2000) begin
      // config churn mid-run must not disturb the latched run
      if (cyc == 2) begin
        start = 1'b1;
        mode = ~v.md;
        amplitude = ~v.amp;
        rate_div = v.rate ^ 16'd5;
        length = v.len + 16'd3;
      end else if (cyc == 3) start = 1'b0;
      stop = v.stop_at != 0 && cnt == v.stop_at &&
             cyc == 1 + cnt * (int'(v.rate) + 1);
      #1;
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (!busy) berr++;
      if (dv) begin
        if (cyc != 1 + cnt * (int'(v.rate) + 1)) terr++;
        check($sformatf("v%0d_d%0d", idx, cnt), d,
              model(v.md, v.amp, cnt, lf));
        if (cnt == 0) check($sformatf("v%0d_d0", idx), d, v.exp_d0);
        lf = adv(lf);
        cnt++;
        last_d = d;
      end else if (d !== last_d) herr++;
      tick();
      cyc++;
    end
    start = 1'b0;
    stop = 1'b0;
    check($sformatf("v%0d_count", idx), cnt, v.exp_n);
    check($sformatf("v%0d_done_cyc", idx), done_cyc, v.exp_done);
    check($sformatf("v%0d_timing", idx), terr, 0);
    check($sformatf("v%0d_hold", idx), herr, 0);
    check($sformatf("v%0d_busy_run", idx), berr, 0);
    check($sformatf("v%0d_busy_done", idx), busy, 0);
    tick();
    check($sformatf("v%0d_done_pulse", idx), {busy, done}, 0);
  endtask

  initial begin
    tbl[0] = '{2'd3, 16'd0, 16'd6, 25'h0, 0, 6, 25'h1D67092, 7};
    tbl[1] = '{2'd0, 16'd3, 16'd4, 25'h0200000, 0, 4, 25'h0200000, 14};
    tbl[2] = '{2'd1, 16'd0, 16'd8, 25'h1C00000, 0, 8, 25'h1C00000, 9};
    tbl[3] = '{2'd2, 16'd0, 16'd40, 25'h1000000, 0, 40, 25'h1000000, 41};
    tbl[4] = '{2'd3, 16'd1, 16'd0, 25'h0, 100, 100, 25'h1D67092, 202};
    tbl[5] = '{2'd2, 16'd2, 16'd20, 25'h0100000, 0, 20, 25'h0100000, 59};
    tbl[6] = '{2'd1, 16'd0, 16'd1, 25'h0FFFFFF, 0, 1, 25'h0FFFFFF, 2};
    tbl[7] = '{2'd0, 16'd0, 16'd0, 25'h1F00000, 3, 3, 25'h1F00000, 5};

    resetn = 1'b0; start = 1'b0; stop = 1'b0;
    mode = '0; rate_div = '0; length = '0; amplitude = '0;
`ifdef IIR_STIM_BACKPRESSURE_EN
    sif.ready_in = 1'b1;
`endif
    repeat (2) @(posedge clk);
    #1;
    check("reset_outs", {busy, done, dv, d}, 0);
    resetn = 1'b1;
    tick();

    // stop, and start together with stop, are no-ops in IDLE
    start = 1'b1; stop = 1'b1;
    tick(); tick();
    check("idle_stop", {busy, done, dv}, 0);
    start = 1'b0; stop = 1'b0;
    tick();

    // reset while a noise run is active
    mode = 2'd3; rate_div = '0; length = '0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    #1;
    check("pre_reset_busy", busy, 1);
    resetn = 1'b0;
    #1;
    check("mid_reset_outs", {busy, done, dv, d}, 0);
    tick();
    check("mid_reset_hold", {busy, done, dv, d}, 0);
    resetn = 1'b1;
    begin : nodone
      int seen = 0;
      repeat (3) begin
        tick();
        if (done || busy) seen++;
      end
      check("reset_no_done", seen, 0);
    end

    for (int i = 0; i < 8; i++) run(i, tbl[i]);

    // start clears d_out: an immediate stop exposes the cleared register
    mode = 2'd1; rate_div = '0; length = 16'd1;
    amplitude = 25'h0123456; start = 1'b1;
    tick();
    start = 1'b0;
    #1;
    check("pre_clear_d", {dv, d}, {1'b1, 25'h0123456});
    tick(); tick();
    amplitude = 25'h0654321; start = 1'b1;
    tick();
    start = 1'b0; stop = 1'b1;
    #1;
    check("stop_first_dv", dv, 0);
    check("start_clears_d", d, 0);
    tick();
    stop = 1'b0;
    #1;
    check("stop_first_done", {busy, done}, 2'b01);
    tick();

`ifdef IIR_STIM_BACKPRESSURE_EN
    begin : bp
      int cnt, held, cyc;
      logic [31:0] lf;
      logic [24:0] hd;
      mode = 2'd3; rate_div = '0; length = 16'd5; start = 1'b1;
      tick();
      start = 1'b0;
      cnt = 0; held = 0; cyc = 0; lf = SEED; hd = '0;
      while (!done && cyc < 200) begin
        sif.ready_in = !(cnt == 2 && held < 10);
        #1;
        if (dv && !sif.ready_in) begin
          if (held == 0) hd = d;
          else check("bp_hold_d", d, hd);
          held++;
        end else if (dv) begin
          check($sformatf("bp_d%0d", cnt), d, model(2'd3, 25'd0, cnt, lf));
          lf = adv(lf);
          cnt++;
        end
        tick();
        cyc++;
      end
      sif.ready_in = 1'b1;
      check("bp_held", held, 10);
      check("bp_count", cnt, 5);
      check("bp_done", done, 1);
      tick();
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
